serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port A, input, WIDTH bits: operand stream, upstream updates it on the clk falling edge.
REQ-005 The block SHALL have port in_valid, input, 1 bit: A holds a valid operand this cycle.
REQ-006 The block SHALL have port S, output, WIDTH bits: registered sum of the last completed operation.
REQ-007 The block SHALL have port Cout, output, 1 bit: registered carry-out of the last completed operation.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that S/Cout were just updated.
REQ-009 The block SHALL have port busy, output, 1 bit: high while A/in_valid are being ignored.

Function
REQ-010 The block SHALL implement FSM states IDLE, GET_B, ADD and DONE.
REQ-011 In IDLE, a rising edge with in_valid=1 SHALL capture A into opA and move to GET_B; with in_valid=0 it stays in IDLE.
REQ-012 In GET_B, a rising edge with in_valid=1 SHALL capture A into opB, clear carry, clear bit index and move to ADD; with in_valid=0 it stays in GET_B and holds opA.
REQ-013 In ADD, each rising edge SHALL process bit i (LSB first): sum_i = opA[i]^opB[i]^c, c = majority(opA[i],opB[i],c), then increment i.
REQ-014 ADD SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, the FSM SHALL load S with all sum bits and Cout with the final carry, then move to DONE.
REQ-015 done SHALL be 1 exactly for the single cycle the FSM is in DONE; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-016 busy SHALL be 1 in ADD and DONE and 0 in IDLE and GET_B.
REQ-017 in_valid and A SHALL be ignored in ADD and DONE; operands presented then are dropped, not queued.
REQ-018 Latency: if opB is captured on edge k, then S/Cout SHALL update on edge k+WIDTH, and done SHALL be high from edge k+WIDTH to edge k+WIDTH+1.
REQ-019 S and Cout SHALL hold their value between completions; intermediate sum bits SHALL never be visible on S.
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH, with overflow reported only on Cout (e.g. 15+1 gives S=0, Cout=1 for WIDTH=4).
REQ-021 A and in_valid SHALL be sampled only on the clk rising edge, so falling-edge-driven stimulus is sampled mid-period and is stable.

Reset
REQ-022 rst=0 SHALL immediately, without a clock, force FSM=IDLE, S=0, Cout=0, done=0, busy=0, and opA, opB, carry and bit index to 0.
REQ-023 While rst=0, all outputs SHALL hold their reset values regardless of clk, A and in_valid.
REQ-024 Reset asserted during GET_B, ADD or DONE SHALL abort the operation: no done pulse, and S/Cout go to 0.
REQ-025 After rst returns to 1, the first rising edge with in_valid=1 SHALL be captured as opA.

Verification
REQ-026 The bench SHALL cover async reset: rst=0 mid-period with FSM in ADD -> S=0, Cout=0, done=0, busy=0 before the next clk edge.
REQ-027 The bench SHALL cover basic add: A=3 then A=5 with in_valid=1 on consecutive edges -> exactly 4 edges after the B capture S=8, Cout=0, and done high for one cycle.
REQ-028 The bench SHALL cover overflow: 15+1 -> S=0, Cout=1; and 15+15 -> S=14, Cout=1.
REQ-029 The bench SHALL cover ignored input: A=9, in_valid=1 during ADD -> result of the in-flight operation unchanged and busy=1; the next operation uses operands presented after done.
REQ-030 The bench SHALL cover GET_B stall: A=2 captured, in_valid=0 for 3 cycles, then A=6 -> S=8, and opA is retained.
REQ-031 The bench SHALL cover reset recovery: reset in the 2nd ADD cycle, release, then 2+2 -> no done during the reset, then S=4, Cout=0, done pulses once.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand stream and result bus of the bit-serial adder.
//   A, in_valid       : operand word and its qualifier (master -> slave)
//   S, Cout           : registered sum / carry of the last completed add
//   done              : one-cycle pulse when S/Cout were just updated
//   busy              : high while operands are being ignored
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic             in_valid;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             done;
  logic             busy;

  modport master (
    output A, in_valid,
    input  S, Cout, done, busy
  );

  modport slave (
    input  A, in_valid,
    output S, Cout, done, busy
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: takes two WIDTH-bit operands from a valid-qualified stream,
// adds them one bit per clock (LSB first) and publishes sum/carry at once.
//   clk  : single clock, rising edge active
//   rst  : asynchronous active-low reset
//   bus  : serial_adder_if.slave (A, in_valid in; S, Cout, done, busy out)
//
// state | meaning
// IDLE  | waiting for operand A
// GET_B | opA held, waiting for operand B
// ADD   | one bit per cycle, WIDTH cycles
// DONE  | S/Cout just loaded, done=1 for this cycle
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, GET_B, ADD, DONE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_sum_acc;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;

  logic               w_bit_a;
  logic               w_bit_b;
  logic               w_sum_bit;
  logic               w_carry;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum_full;
  logic               w_done;
  logic               w_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE:  if (bus.in_valid) w_next_state = GET_B;
      GET_B: if (bus.in_valid) w_next_state = ADD;
      ADD: begin
        w_busy = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Current bit slice of the full adder.
  always_comb begin
    w_bit_a   = r_op_a[r_idx];
    w_bit_b   = r_op_b[r_idx];
    w_sum_bit = w_bit_a ^ w_bit_b ^ r_carry;
    w_carry   = (w_bit_a & w_bit_b) | (w_bit_a & r_carry) | (w_bit_b & r_carry);
    w_last    = (r_idx == IDX_W'(WIDTH - 1));
  end

  // Accumulated sum with the bit computed this cycle merged in, so the final
  // cycle can load S in one shot without exposing partial results.
  always_comb begin
    w_sum_full        = r_sum_acc;
    w_sum_full[r_idx] = w_sum_bit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_sum_acc <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_s       <= '0;
      r_cout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) r_op_a <= bus.A;
        GET_B: if (bus.in_valid) begin
          r_op_b    <= bus.A;
          r_sum_acc <= '0;
          r_carry   <= 1'b0;
          r_idx     <= '0;
        end
        ADD: begin
          r_sum_acc <= w_sum_full;
          r_carry   <= w_carry;
          r_idx     <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_s    <= w_sum_full;
            r_cout <= w_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.S    = r_s;
  assign bus.Cout = r_cout;
  assign bus.done = w_done;
  assign bus.busy = w_busy;
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  // reference-model state: result of the last completed operation
  logic [W-1:0] exp_s;
  logic         exp_c;

  serial_adder_if #(.WIDTH(W)) u_if ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Full operation: A then (after 'stall' idle cycles) B, with optional
  // garbage operands pushed during ADD/DONE, which must be dropped.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit inject, input string tag);
    logic [W:0] total;
    total = {1'b0, a} + {1'b0, b};
    @(negedge clk); u_if.A = a; u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    chk(u_if.busy, 0, {tag, " busy_getb"});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); u_if.A = W'($urandom); u_if.in_valid = 1'b0;
      @(posedge clk); #1;
      chk(u_if.busy, 0, {tag, " busy_stall"});
    end
    @(negedge clk); u_if.A = b; u_if.in_valid = 1'b1;
    @(posedge clk); #1;                       // edge k: opB captured
    chk(u_if.busy, 1, {tag, " busy_add"});
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      u_if.A = inject ? W'(9) : W'($urandom);
      u_if.in_valid = inject;
      @(posedge clk); #1;
      chk(u_if.done, 0, {tag, " done_early"});
      chk({u_if.Cout, u_if.S}, {exp_c, exp_s}, {tag, " hold"});
    end
    @(negedge clk);
    @(posedge clk); #1;                       // edge k+W
    exp_s = total[W-1:0];
    exp_c = total[W];
    chk(u_if.S, exp_s, {tag, " S"});
    chk(u_if.Cout, exp_c, {tag, " Cout"});
    chk(u_if.done, 1, {tag, " done"});
    chk(u_if.busy, 1, {tag, " busy_done"});
    @(negedge clk); u_if.in_valid = 1'b0;
    @(posedge clk); #1;
    chk(u_if.done, 0, {tag, " done_pulse"});
    chk(u_if.busy, 0, {tag, " busy_idle"});
    chk({u_if.Cout, u_if.S}, {exp_c, exp_s}, {tag, " S_hold"});
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    exp_s = '0; exp_c = 1'b0;
    rst = 1'b0; u_if.A = '0; u_if.in_valid = 1'b0;
    #2;
    chk({u_if.busy, u_if.done, u_if.Cout, u_if.S}, 0, "reset_state");
    repeat (2) @(negedge clk);
    u_if.in_valid = 1'b1; u_if.A = 4'd7;
    @(posedge clk); #1;
    chk({u_if.busy, u_if.done, u_if.Cout, u_if.S}, 0, "reset_held");
    @(negedge clk); u_if.in_valid = 1'b0; rst = 1'b1;

    run_op(4'd3, 4'd5, 0, 1'b0, "basic");
    run_op(4'd15, 4'd1, 0, 1'b0, "ovf_15p1");
    run_op(4'd15, 4'd15, 0, 1'b0, "ovf_15p15");
    run_op(4'd4, 4'd7, 0, 1'b1, "ignore");
    run_op(4'd1, 4'd2, 0, 1'b0, "after_ignore");
    run_op(4'd2, 4'd6, 3, 1'b0, "stall");

    // abort in the 2nd ADD cycle
    @(negedge clk); u_if.A = 4'd6; u_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); u_if.A = 4'd5;
    @(posedge clk);                           // B captured, 1st ADD cycle
    @(negedge clk); u_if.in_valid = 1'b0;
    @(posedge clk); #2;                       // 2nd ADD cycle, mid-period
    chk(u_if.busy, 1, "abort_pre_busy");
    rst = 1'b0;
    #1;
    chk({u_if.busy, u_if.done, u_if.Cout, u_if.S}, 0, "async_reset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); u_if.A = W'($urandom); u_if.in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk({u_if.busy, u_if.done, u_if.Cout, u_if.S}, 0, "reset_hold");
    end
    @(negedge clk); u_if.in_valid = 1'b0; rst = 1'b1;
    exp_s = '0; exp_c = 1'b0;
    run_op(4'd2, 4'd2, 0, 1'b0, "recover");

    for (int n = 0; n < 10; n++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)),
             1'($urandom), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
